// File: rtl/cpu_irq_if.sv
// cpu_irq_if: CPU-side bus bundle between a Z80 core and the interrupt
// controller.
//
//   m1, iorq   CPU M1 and IORQ strobes, active-low (driven by the CPU)
//   int_n      maskable interrupt request to the CPU, active-low
//   nmi        non-maskable interrupt to the CPU, active-low
//   vector     IM2 vector byte, valid while vector_oe=1
//   vector_oe  data-bus mux select for the acknowledge cycle
//
// The CPU interrupt line is called int_n because "int" is an SV keyword.
// The master modport is the CPU side; the slave modport is the controller.
interface cpu_irq_if;
  logic       m1;
  logic       iorq;
  logic       int_n;
  logic       nmi;
  logic [7:0] vector;
  logic       vector_oe;

  modport master (output m1, iorq, input int_n, nmi, vector, vector_oe);
  modport slave  (input m1, iorq, output int_n, nmi, vector, vector_oe);
endinterface

// File: rtl/cpu_irq.sv
// cpu_irq: prioritised, maskable, edge-triggered interrupt controller in
// front of a Z80 core, with an IM2 vector source and an NMI pulse shaper.
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-low reset
//   cep          CPU clock enable; state advances only on clock edges with cep=1
//   bus          cpu_irq_if.slave (m1, iorq in; int_n, nmi, vector, vector_oe out)
//   req          per-channel interrupt requests, rising-edge sensitive
//   mask         per-channel enable, 1 = enabled
//   nmi_req      NMI request, rising-edge sensitive
//   grant        index of the channel currently presented
//   overrun      (CPU_IRQ_OVERRUN_EN only) sticky per-channel lost-request flags
//   overrun_clr  (CPU_IRQ_OVERRUN_EN only) clears all overrun flags
//
// Optional feature macro: CPU_IRQ_OVERRUN_EN adds the overrun flags. Without
// it a repeated edge on an already-pending channel is merged silently.
//
// Channel 0 has the highest priority. A request edge sets pending on its
// tick; the next tick in IDLE presents the lowest pending, enabled channel.
// int is held low for at most INT_LEN ticks waiting for the acknowledge
// (m1=0 and iorq=0); an unacknowledged request is dropped.
module cpu_irq #(
  parameter int         CHANNELS    = 4,
  parameter int         INT_LEN     = 32,
  parameter int         NMI_LEN     = 32,
  parameter logic [7:0] VECTOR_BASE = 8'hF0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cep,
  cpu_irq_if.slave            bus,
  input  logic [CHANNELS-1:0] req,
  input  logic [CHANNELS-1:0] mask,
  input  logic                nmi_req,
  output logic [2:0]          grant
`ifdef CPU_IRQ_OVERRUN_EN
  ,
  output logic [CHANNELS-1:0] overrun,
  input  logic                overrun_clr
`endif
);

  localparam logic [7:0] INT_LEN_C = 8'(INT_LEN);
  localparam logic [7:0] NMI_LEN_C = 8'(NMI_LEN);

  typedef enum logic [1:0] {IDLE, ASSERT, ACK} state_t;

  state_t              state;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] pending_next;
  logic [CHANNELS-1:0] req_d;
  logic [CHANNELS-1:0] req_edge;
  logic [CHANNELS-1:0] clr_oh;
  logic [7:0]          int_cnt;
  logic [7:0]          nmi_cnt;
  logic                nmi_req_d;
  logic [2:0]          first_idx;
  logic                ack;
  logic                mask_off;
  logic                timeout;
  logic                clr_any;

  assign req_edge = req & ~req_d;
  assign ack      = ~bus.m1 & ~bus.iorq;
  // The counter is loaded with INT_LEN on assertion, so reaching 1 here
  // means this tick is the INT_LEN-th one with int low.
  assign timeout  = (int_cnt == 8'd1);
  // Ack wins over a mask drop, which wins over timeout; only ack and a
  // genuine timeout consume the pending bit.
  assign clr_any  = (state == ASSERT) && (ack || (!mask_off && timeout));

  // Lowest-indexed pending and enabled channel.
  always_comb begin
    first_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending[i] && mask[i]) first_idx = 3'(i);
    end
  end

  always_comb begin
    mask_off = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == 3'(i) && !mask[i]) mask_off = 1'b1;
    end
  end

`ifdef CPU_IRQ_OVERRUN_EN
  logic [CHANNELS-1:0] overrun_next;
  logic                timeout_hit;

  assign timeout_hit = (state == ASSERT) && !ack && !mask_off && timeout;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign clr_oh[gi]       = clr_any && (grant == 3'(gi));
      // A new edge on the clearing tick keeps the channel pending.
      assign pending_next[gi] = req_edge[gi] | (pending[gi] & ~clr_oh[gi]);
`ifdef CPU_IRQ_OVERRUN_EN
      assign overrun_next[gi] = (req_edge[gi] & pending[gi])
                              | (timeout_hit && grant == 3'(gi))
                              | (overrun[gi] & ~overrun_clr);
`endif
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      grant         <= '0;
      pending       <= '0;
      req_d         <= '0;
      int_cnt       <= '0;
      bus.int_n     <= 1'b1;
      bus.vector    <= VECTOR_BASE;
      bus.vector_oe <= 1'b0;
    end else if (cep) begin
      req_d   <= req;
      pending <= pending_next;
      case (state)
        IDLE: begin
          if (|(pending & mask)) begin
            grant     <= first_idx;
            int_cnt   <= INT_LEN_C;
            bus.int_n <= 1'b0;
            state     <= ASSERT;
          end
        end
        ASSERT: begin
          int_cnt <= int_cnt - 8'd1;
          if (ack) begin
            bus.int_n     <= 1'b1;
            bus.vector    <= VECTOR_BASE | {4'b0000, grant, 1'b0};
            bus.vector_oe <= 1'b1;
            state         <= ACK;
          end else if (mask_off || timeout) begin
            bus.int_n <= 1'b1;
            state     <= IDLE;
          end
        end
        ACK: begin
          if (!ack) begin
            bus.vector_oe <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NMI pulse: a new edge is accepted only while nmi is high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nmi_req_d <= 1'b0;
      nmi_cnt   <= '0;
      bus.nmi   <= 1'b1;
    end else if (cep) begin
      nmi_req_d <= nmi_req;
      if (!bus.nmi) begin
        nmi_cnt <= nmi_cnt - 8'd1;
        if (nmi_cnt == 8'd1) bus.nmi <= 1'b1;
      end else if (nmi_req && !nmi_req_d) begin
        nmi_cnt <= NMI_LEN_C;
        bus.nmi <= 1'b0;
      end
    end
  end

`ifdef CPU_IRQ_OVERRUN_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun <= '0;
    end else if (cep) begin
      overrun <= overrun_next;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_irq.sv
// tb_cpu_irq: self-checking bench for cpu_irq. Directed scenarios followed
// by randomized stimulus, all checked every tick against a behavioural
// model of the controller kept in this file.
module tb_cpu_irq;
  localparam int         CH      = 4;
  localparam int         INT_LEN = 32;
  localparam int         NMI_LEN = 32;
  localparam logic [7:0] VB      = 8'hF0;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cep = 1'b0;
  logic [CH-1:0] req = '0;
  logic [CH-1:0] mask = '0;
  logic          nmi_req = 1'b0;
  logic [2:0]    grant;
`ifdef CPU_IRQ_OVERRUN_EN
  logic [CH-1:0] overrun;
  logic          overrun_clr = 1'b0;
`endif

  cpu_irq_if bus();

  cpu_irq #(
    .CHANNELS(CH), .INT_LEN(INT_LEN), .NMI_LEN(NMI_LEN), .VECTOR_BASE(VB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cep(cep),
    .bus(bus),
    .req(req),
    .mask(mask),
    .nmi_req(nmi_req),
    .grant(grant)
`ifdef CPU_IRQ_OVERRUN_EN
    ,
    .overrun(overrun),
    .overrun_clr(overrun_clr)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Behavioural model: what the CPU should see, tracked as "who is being
  // presented and for how long" rather than as the RTL's state machine.
  bit          presenting;  // int currently held low
  bit          acking;      // vector currently on the bus
  int          chan;        // channel presented / last presented
  int          held;        // ticks int has been low beyond the first
  int          nmi_left;    // remaining ticks of nmi low
  bit [CH-1:0] pend;
  bit [CH-1:0] req_prev;
  bit          nreq_prev;
`ifdef CPU_IRQ_OVERRUN_EN
  bit [CH-1:0] ovr;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    presenting = 0; acking = 0; chan = 0; held = 0; nmi_left = 0;
    pend = '0; req_prev = '0; nreq_prev = 0;
`ifdef CPU_IRQ_OVERRUN_EN
    ovr = '0;
`endif
  endtask

  task automatic model_tick();
    bit [CH-1:0] edges;
    bit [CH-1:0] clr;
    bit [CH-1:0] lost;
    bit          ack_now;
    if (!cep) return;
    edges   = req & ~req_prev;
    ack_now = !bus.m1 && !bus.iorq;
    clr     = '0;
    lost    = '0;
    if (presenting) begin
      if (ack_now) begin
        clr[chan] = 1; presenting = 0; acking = 1;
      end else if (!mask[chan]) begin
        presenting = 0;
      end else begin
        held++;
        if (held >= INT_LEN) begin
          clr[chan] = 1; lost[chan] = 1; presenting = 0;
        end
      end
    end else if (acking) begin
      if (!ack_now) acking = 0;
    end else if ((pend & mask) != '0) begin
      for (int i = CH - 1; i >= 0; i--) if (pend[i] && mask[i]) chan = i;
      presenting = 1; held = 0;
    end
`ifdef CPU_IRQ_OVERRUN_EN
    ovr = (overrun_clr ? '0 : ovr) | (edges & pend) | lost;
`endif
    pend = (pend & ~clr) | edges;
    if (nmi_left > 0) nmi_left--;
    else if (nmi_req && !nreq_prev) nmi_left = NMI_LEN;
    req_prev  = req;
    nreq_prev = nmi_req;
  endtask

  task automatic compare_all();
    check("int", 32'(bus.int_n), 32'(!presenting));
    check("nmi", 32'(bus.nmi), 32'(nmi_left == 0));
    check("vector_oe", 32'(bus.vector_oe), 32'(acking));
    check("grant", 32'(grant), 32'(chan));
    if (acking) check("vector", 32'(bus.vector), 32'(VB | 8'(chan << 1)));
`ifdef CPU_IRQ_OVERRUN_EN
    check("overrun", 32'(overrun), 32'(ovr));
`endif
  endtask

  // One tick: drive inputs, let the edge happen, then compare #1 later.
  task automatic step(input logic c, input logic [CH-1:0] r, input logic [CH-1:0] mk,
                      input logic m1v, input logic iorqv, input logic nr);
    cep = c; req = r; mask = mk; bus.m1 = m1v; bus.iorq = iorqv; nmi_req = nr;
    @(posedge clock);
    model_tick();
    #1;
    compare_all();
  endtask

  initial begin
    int low_cnt;
    int falls;
    bit prev_nmi;
    bus.m1 = 1'b1;
    bus.iorq = 1'b1;
    model_reset();

    // Reset values
    #22;
    check("rst_int", 32'(bus.int_n), 32'd1);
    check("rst_nmi", 32'(bus.nmi), 32'd1);
    check("rst_oe", 32'(bus.vector_oe), 32'd0);
    check("rst_vector", 32'(bus.vector), 32'(VB));
    check("rst_grant", 32'(grant), 32'd0);
    reset = 1'b1;

    // Single request on channel 2, acknowledged
    step(1, 4'b0100, 4'b1111, 1, 1, 0);
    step(1, 4'b0000, 4'b1111, 1, 1, 0);
    check("t1_int_low", 32'(bus.int_n), 32'd0);
    check("t1_grant", 32'(grant), 32'd2);
    step(1, 4'b0000, 4'b1111, 0, 0, 0);
    check("t1_vector", 32'(bus.vector), 32'hF4);
    $display("ack ch=%0d vector=%02h", grant, bus.vector);
    step(1, 4'b0000, 4'b1111, 1, 1, 0);
    check("t1_oe_off", 32'(bus.vector_oe), 32'd0);

    // Two simultaneous requests: priority order 1 then 3
    step(1, 4'b1010, 4'b1111, 1, 1, 0);
    step(1, 4'b0000, 4'b1111, 1, 1, 0);
    step(1, 4'b0000, 4'b1111, 0, 0, 0);
    check("t2_vec1", 32'(bus.vector), 32'hF2);
    $display("ack ch=%0d vector=%02h", grant, bus.vector);
    step(1, 4'b0000, 4'b1111, 1, 1, 0);
    step(1, 4'b0000, 4'b1111, 1, 1, 0);
    check("t2_reassert", 32'(bus.int_n), 32'd0);
    step(1, 4'b0000, 4'b1111, 0, 0, 0);
    check("t2_vec2", 32'(bus.vector), 32'hF6);
    $display("ack ch=%0d vector=%02h", grant, bus.vector);
    step(1, 4'b0000, 4'b1111, 1, 1, 0);

    // Unacknowledged request times out after INT_LEN ticks
    step(1, 4'b0001, 4'b1111, 1, 1, 0);
    low_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 4'b0000, 4'b1111, 1, 1, 0);
      if (bus.int_n == 1'b0) low_cnt++;
    end
    check("t3_int_len", 32'(low_cnt), 32'(INT_LEN));
    $display("timeout ch=0 int_low_ticks=%0d", low_cnt);

    // Mask drop during ASSERT, then re-enable
    step(1, 4'b0010, 4'b1111, 1, 1, 0);
    step(1, 4'b0000, 4'b1111, 1, 1, 0);
    step(1, 4'b0000, 4'b1101, 1, 1, 0);
    check("t4_masked_int", 32'(bus.int_n), 32'd1);
    step(1, 4'b0000, 4'b1111, 1, 1, 0);
    check("t4_reassert", 32'(bus.int_n), 32'd0);
    check("t4_grant", 32'(grant), 32'd1);
    step(1, 4'b0000, 4'b1111, 0, 0, 0);
    $display("ack ch=%0d vector=%02h", grant, bus.vector);
    step(1, 4'b0000, 4'b1111, 1, 1, 0);

    // NMI with a second edge during the pulse
    low_cnt = 0; falls = 0; prev_nmi = 1'b1;
    for (int i = 0; i < 45; i++) begin
      step(1, 4'b0000, 4'b1111, 1, 1, (i == 0 || i == 5));
      if (bus.nmi == 1'b0) low_cnt++;
      if (prev_nmi && bus.nmi == 1'b0) falls++;
      prev_nmi = bus.nmi;
    end
    check("t5_nmi_len", 32'(low_cnt), 32'(NMI_LEN));
    check("t5_nmi_pulses", 32'(falls), 32'd1);
    $display("nmi low_ticks=%0d pulses=%0d", low_cnt, falls);

`ifdef CPU_IRQ_OVERRUN_EN
    overrun_clr = 1'b1;
    step(1, 4'b0000, 4'b1111, 1, 1, 0);
    overrun_clr = 1'b0;
    check("t6_clr0", 32'(overrun), 32'd0);
    step(1, 4'b0001, 4'b1111, 1, 1, 0);
    step(1, 4'b0000, 4'b1111, 1, 1, 0);
    step(1, 4'b0001, 4'b1111, 1, 1, 0);
    check("t6_overrun", 32'(overrun), 32'b0001);
    step(1, 4'b0000, 4'b1111, 0, 0, 0);
    step(1, 4'b0000, 4'b1111, 1, 1, 0);
    overrun_clr = 1'b1;
    step(1, 4'b0000, 4'b1111, 1, 1, 0);
    overrun_clr = 1'b0;
    check("t6_clr", 32'(overrun), 32'd0);
    $display("overrun cleared=%b", overrun);
`endif

    // Asynchronous reset in the middle of ASSERT
    step(1, 4'b0100, 4'b1111, 1, 1, 0);
    step(1, 4'b0000, 4'b1111, 1, 1, 0);
    #2 reset = 1'b0;
    #1;
    check("t7_rst_int", 32'(bus.int_n), 32'd1);
    check("t7_rst_grant", 32'(grant), 32'd0);
    model_reset();
    #10 reset = 1'b1;
    $display("async reset mid-assert int=%0b", bus.int_n);

    // Randomized stimulus
    for (int i = 0; i < 3000; i++) begin
      logic [CH-1:0] r, mk;
      r = req;
      for (int b = 0; b < CH; b++) if ($urandom % 6 == 0) r[b] = ~r[b];
      mk = mask;
      if ($urandom % 40 == 0) mk = CH'($urandom);
      else if ($urandom % 10 == 0) mk = '1;
`ifdef CPU_IRQ_OVERRUN_EN
      overrun_clr = ($urandom % 25 == 0);
`endif
      step(($urandom % 8) != 0, r, mk, ($urandom % 3) != 0, ($urandom % 3) != 0,
           ($urandom % 20) == 0 ? ~nmi_req : nmi_req);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
